// File: rtl/lc3_mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lc3_mem_arb_pkg
//  Description : Shared types and constants for the LC3 memory arbiter.
//                Holds the arbiter FSM state encoding, the wait-state limit
//                and a helper that sizes channel-index fields.
//  Revision    : 1.0 - initial release
// ============================================================================
package lc3_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    // Largest wait-state count the 4-bit programming range allows.
    localparam int MAX_WAIT_CYC = 15;

    // Width of a channel index; a single channel still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lc3_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : lc3_rr_arbiter
//  Description : Combinational winner selection for the memory arbiter.
//                Round-robin: first requester above ptr, wrapping.
//                Fixed priority (FIXED_PRIO=1): lowest requesting index.
//  Ports       : req     - per-channel request vector
//                ptr     - last granted channel (round-robin only)
//                win_oh  - one-hot winner, zero when nothing requests
//                win_idx - binary index of the winner
//                any     - at least one channel is requesting
//  Revision    : 1.0 - initial release
// ============================================================================
module lc3_rr_arbiter #(
    parameter int NUM_CH     = 2,
    parameter int FIXED_PRIO = 0,
    parameter int IDX_W      = 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [NUM_CH-1:0] win_oh,
    output logic [IDX_W-1:0]  win_idx,
    output logic              any
);

    assign any = |req;

    generate
        if (FIXED_PRIO != 0) begin : g_fixed
            logic w_found;
            // The pointer has no meaning in fixed mode.
            logic w_unused_ptr;
            assign w_unused_ptr = ^ptr;

            always_comb begin
                win_oh  = '0;
                win_idx = '0;
                w_found = 1'b0;
                for (int i = 0; i < NUM_CH; i++) begin
                    if (req[i] && !w_found) begin
                        w_found    = 1'b1;
                        win_oh[i]  = 1'b1;
                        win_idx    = IDX_W'(i);
                    end
                end
            end
        end else begin : g_rr
            logic             w_found;
            int               w_pos;
            logic [IDX_W-1:0] w_idx;

            // Scan offsets 1..NUM_CH from the pointer so the channel granted
            // last is considered last.
            always_comb begin
                win_oh  = '0;
                win_idx = '0;
                w_found = 1'b0;
                w_pos   = 0;
                w_idx   = '0;
                for (int off = 1; off <= NUM_CH; off++) begin
                    w_pos = int'(ptr) + off;
                    if (w_pos >= NUM_CH) begin
                        w_pos = w_pos - NUM_CH;
                    end
                    w_idx = IDX_W'(w_pos);
                    if (req[w_idx] && !w_found) begin
                        w_found        = 1'b1;
                        win_oh[w_idx]  = 1'b1;
                        win_idx        = w_idx;
                    end
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/lc3_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : lc3_mem_arbiter
//  Description : N-channel arbiter in front of a single-port LC3 memory.
//                One access at a time, WAIT_CYC+1 cycles of ACCESS, then a
//                one-cycle DONE carrying the registered response.
//  Ports       : clock, reset_n      - clock, synchronous active-low reset
//                req/we/addr/wdata   - per-channel request bundle (ch0 LSBs)
//                gnt                 - one-hot accept pulse
//                rvalid/rdata        - one-hot completion pulse, read data
//                busy                - high in ACCESS and DONE
//                mem_*               - single-port memory interface
//  Revision    : 1.0 - initial release
// ============================================================================
module lc3_mem_arbiter
    import lc3_mem_arb_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int WAIT_CYC   = 2,
    parameter int FIXED_PRIO = 0
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [NUM_CH-1:0]        req,
    input  logic [NUM_CH-1:0]        we,
    input  logic [NUM_CH*ADDR_W-1:0] addr,
    input  logic [NUM_CH*DATA_W-1:0] wdata,
    output logic [NUM_CH-1:0]        gnt,
    output logic [NUM_CH-1:0]        rvalid,
    output logic [DATA_W-1:0]        rdata,
    output logic                     busy,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata
);

    localparam int IDX_W    = idx_width(NUM_CH);
    localparam int EFF_WAIT = (WAIT_CYC > MAX_WAIT_CYC) ? MAX_WAIT_CYC :
                              (WAIT_CYC < 0) ? 0 : WAIT_CYC;
    localparam int CNT_W    = (EFF_WAIT > 0) ? $clog2(EFF_WAIT + 1) : 1;

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    logic                w_take;
    logic                w_finish;

    logic [CNT_W-1:0]    r_cnt;
    logic [IDX_W-1:0]    r_ptr;
    logic [NUM_CH-1:0]   r_sel_oh;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic [NUM_CH-1:0]   r_gnt;
    logic [NUM_CH-1:0]   r_rvalid;
    logic                r_mem_en;

    logic [NUM_CH-1:0]   w_win_oh;
    logic [IDX_W-1:0]    w_win_idx;
    logic                w_any;
    logic                w_sel_we;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;

    lc3_rr_arbiter #(
        .NUM_CH     (NUM_CH),
        .FIXED_PRIO (FIXED_PRIO),
        .IDX_W      (IDX_W)
    ) u_arb (
        .req     (req),
        .ptr     (r_ptr),
        .win_oh  (w_win_oh),
        .win_idx (w_win_idx),
        .any     (w_any)
    );

    // One-hot AND-OR mux of the winning channel's request fields.
    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_sel_we    = w_sel_we    | (we[i] & w_win_oh[i]);
            w_sel_addr  = w_sel_addr  | (addr[i*ADDR_W +: ADDR_W] & {ADDR_W{w_win_oh[i]}});
            w_sel_wdata = w_sel_wdata | (wdata[i*DATA_W +: DATA_W] & {DATA_W{w_win_oh[i]}});
        end
    end

    // Next-state logic. DONE samples req exactly like IDLE so back-to-back
    // accesses run at one per WAIT_CYC+2 cycles.
    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_take      = 1'b1;
                    w_state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (r_cnt == '0) begin
                    w_finish    = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (w_any) begin
                    w_take      = 1'b1;
                    w_state_nxt = ACCESS;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_cnt    <= '0;
            r_ptr    <= IDX_W'(NUM_CH - 1);
            r_sel_oh <= '0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_gnt    <= '0;
            r_rvalid <= '0;
            r_mem_en <= 1'b0;
        end else begin
            r_gnt    <= '0;
            r_rvalid <= '0;
            if (w_take) begin
                r_sel_oh <= w_win_oh;
                r_we     <= w_sel_we;
                r_addr   <= w_sel_addr;
                r_wdata  <= w_sel_wdata;
                r_gnt    <= w_win_oh;
                r_ptr    <= w_win_idx;
                r_cnt    <= CNT_W'(EFF_WAIT);
                r_mem_en <= 1'b1;
            end
            if (r_state == ACCESS && !w_finish) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_finish) begin
                r_mem_en <= 1'b0;
                r_rvalid <= r_sel_oh;
                if (!r_we) begin
                    r_rdata <= mem_rdata;
                end
            end
        end
    end

    assign gnt       = r_gnt;
    assign rvalid    = r_rvalid;
    assign rdata     = r_rdata;
    assign busy      = (r_state != IDLE);
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_en & r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_lc3_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lc3_mem_arbiter
//  Description : Scoreboard bench for lc3_mem_arbiter. One 2-channel
//                round-robin instance (WAIT_CYC=2) and one 4-channel
//                fixed-priority instance (WAIT_CYC=0) share clock and reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lc3_mem_arbiter;

    typedef struct {
        int          ch;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    exp_t        q2[$];
    exp_t        q4[$];
    exp_t        e2;
    exp_t        e4;
    int          c;

    // 2-channel round-robin instance
    logic [1:0]  req, we, gnt, rvalid;
    logic [31:0] addr, wdata;
    logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic        busy, mem_en, mem_we;

    // 4-channel fixed-priority instance
    logic [3:0]  req4, we4, gnt4, rvalid4;
    logic [63:0] addr4, wdata4;
    logic [15:0] rdata4, mem_addr4, mem_wdata4, mem_rdata4;
    logic        busy4, mem_en4, mem_we4;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [15:0] fmem(input logic [15:0] a);
        return (a == 16'h3000) ? 16'h1234 : (a ^ 16'hA5A5);
    endfunction

    assign mem_rdata  = fmem(mem_addr);
    assign mem_rdata4 = fmem(mem_addr4);

    lc3_mem_arbiter #(
        .NUM_CH(2), .ADDR_W(16), .DATA_W(16), .WAIT_CYC(2), .FIXED_PRIO(0)
    ) dut (
        .clock(clock), .reset_n(reset_n), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .busy(busy),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    lc3_mem_arbiter #(
        .NUM_CH(4), .ADDR_W(16), .DATA_W(16), .WAIT_CYC(0), .FIXED_PRIO(1)
    ) dut_fp (
        .clock(clock), .reset_n(reset_n), .req(req4), .we(we4), .addr(addr4),
        .wdata(wdata4), .gnt(gnt4), .rvalid(rvalid4), .rdata(rdata4), .busy(busy4),
        .mem_en(mem_en4), .mem_we(mem_we4), .mem_addr(mem_addr4),
        .mem_wdata(mem_wdata4), .mem_rdata(mem_rdata4)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic push2(input int ch, input logic [15:0] d, input int cy);
        exp_t e;
        e.ch = ch; e.data = d; e.cyc = cy;
        q2.push_back(e);
    endtask

    task automatic push4(input int ch, input logic [15:0] d, input int cy);
        exp_t e;
        e.ch = ch; e.data = d; e.cyc = cy;
        q4.push_back(e);
    endtask

    // Monitor: every completion pulse must match the oldest expected entry.
    always @(negedge clock) begin
        if ((|rvalid) === 1'b1) begin
            if (q2.size() == 0) begin
                total++; bad++;
                $display("FAIL rv2_unexpected: got rvalid=%b required none", rvalid);
            end else begin
                e2 = q2.pop_front();
                check("rv2_onehot", {30'd0, rvalid}, 32'(1 << e2.ch));
                check("rv2_rdata",  {16'd0, rdata}, {16'd0, e2.data});
                check("rv2_cycle",  cyc, e2.cyc);
                check("rv2_no_gnt", {30'd0, gnt}, 32'd0);
            end
        end
        if ((|rvalid4) === 1'b1) begin
            if (q4.size() == 0) begin
                total++; bad++;
                $display("FAIL rv4_unexpected: got rvalid=%b required none", rvalid4);
            end else begin
                e4 = q4.pop_front();
                check("rv4_onehot", {28'd0, rvalid4}, 32'(1 << e4.ch));
                check("rv4_rdata",  {16'd0, rdata4}, {16'd0, e4.data});
                check("rv4_cycle",  cyc, e4.cyc);
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        req = '0; we = '0; addr = '0; wdata = '0;
        req4 = '0; we4 = '0; addr4 = '0; wdata4 = '0;

        // Reset state
        repeat (3) tick();
        check("rst_gnt",    {30'd0, gnt}, 0);
        check("rst_rvalid", {30'd0, rvalid}, 0);
        check("rst_rdata",  {16'd0, rdata}, 0);
        check("rst_busy",   {31'd0, busy}, 0);
        check("rst_mem",    {mem_en, mem_we, mem_addr, mem_wdata[13:0]}, 0);
        check("rst_busy4",  {31'd0, busy4}, 0);
        reset_n = 1'b1;
        tick();

        // Both channels request, ch0 keeps requesting: order ch0, ch1, ch0
        req = 2'b11; addr = {16'h0020, 16'h0010}; c = cyc;
        push2(0, 16'hA5B5, c + 4);
        push2(1, 16'hA585, c + 8);
        push2(0, 16'hA5B5, c + 12);
        for (int k = 1; k <= 12; k++) begin
            tick();
            case (k)
                1: check("rr_gnt_a", {30'd0, gnt}, 32'b01);
                4: check("rr_done",  {30'd0, busy, mem_en}, 32'b10);
                5: begin check("rr_gnt_b", {30'd0, gnt}, 32'b10); req[1] = 1'b0; end
                9: begin check("rr_gnt_c", {30'd0, gnt}, 32'b01); req[0] = 1'b0; end
                default: ;
            endcase
        end
        tick();

        // Single read of 0x3000, memory returns 0x1234
        req = 2'b01; addr = {16'h0000, 16'h3000}; c = cyc;
        push2(0, 16'h1234, c + 4);
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 1) begin
                check("rd_gnt", {30'd0, gnt}, 32'b01);
                req = 2'b00;
            end
            if (k <= 3) begin
                check("rd_mem_en",   {31'd0, mem_en}, 1);
                check("rd_mem_addr", {16'd0, mem_addr}, 32'h3000);
                check("rd_mem_we",   {31'd0, mem_we}, 0);
            end else begin
                check("rd_mem_off",  {31'd0, mem_en}, 0);
            end
        end
        tick();

        // ch1 writes 0xBEEF to 0x4000; rdata must keep 0x1234
        req = 2'b10; we = 2'b10; addr = {16'h4000, 16'h0000};
        wdata = {16'hBEEF, 16'h0000}; c = cyc;
        push2(1, 16'h1234, c + 4);
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 1) begin
                check("wr_gnt", {30'd0, gnt}, 32'b10);
                req = 2'b00; we = 2'b00;
            end
            if (k <= 3) begin
                check("wr_mem", {mem_en, mem_we, mem_addr[13:0], mem_wdata},
                                {1'b1, 1'b1, 14'h0000, 16'hBEEF});
            end else begin
                check("wr_mem_we_off", {31'd0, mem_we}, 0);
            end
        end
        repeat (3) tick();

        // Reset during the second ACCESS cycle aborts the access
        req = 2'b01; addr = {16'h0000, 16'h0030};
        tick();
        check("ab_gnt", {30'd0, gnt}, 32'b01);
        req = 2'b00;
        tick();
        reset_n = 1'b0;
        tick();
        check("ab_mem_en", {31'd0, mem_en}, 0);
        check("ab_busy",   {31'd0, busy}, 0);
        check("ab_rdata",  {16'd0, rdata}, 0);
        reset_n = 1'b1;
        repeat (3) tick();
        req = 2'b10; addr = {16'h0040, 16'h0000}; c = cyc;
        push2(1, 16'hA5E5, c + 4);
        tick();
        check("ab_fresh_gnt", {30'd0, gnt}, 32'b10);
        req = 2'b00;
        repeat (5) tick();

        // Fixed priority, 4 channels, no wait states: ch0 starves ch3
        req4 = 4'b1001; addr4 = {16'h0300, 32'h0, 16'h0100}; c = cyc;
        push4(0, 16'hA4A5, c + 2);
        push4(0, 16'hA4A5, c + 4);
        push4(0, 16'hA4A5, c + 6);
        push4(3, 16'hA6A5, c + 8);
        for (int k = 1; k <= 8; k++) begin
            tick();
            case (k)
                1, 3: check("fp_gnt_ch0", {28'd0, gnt4}, 32'b0001);
                2: check("fp_done_mem_en", {31'd0, mem_en4}, 0);
                5: begin check("fp_gnt_ch0_last", {28'd0, gnt4}, 32'b0001); req4[0] = 1'b0; end
                7: begin check("fp_gnt_ch3", {28'd0, gnt4}, 32'b1000); req4 = 4'b0000; end
                default: ;
            endcase
        end
        repeat (3) tick();

        check("q2_drained", q2.size(), 0);
        check("q4_drained", q4.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
